// File: rtl/meta_port_arbiter.sv
// Round-robin arbiter sharing one single-port metadata SRAM between DMA, SCH and CSR ports.
// Optional per-port grant/stall counters are compiled in with META_ARB_PERF_EN.
module meta_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    input  logic              sch_req,
    input  logic [ADDR_W-1:0] sch_addr,
    output logic              sch_gnt,
    output logic [DATA_W-1:0] sch_rdata,
    output logic              sch_rvalid,
    input  logic              csr_req,
    input  logic              csr_we,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [DATA_W-1:0] csr_wdata,
    output logic              csr_gnt,
    output logic [DATA_W-1:0] csr_rdata,
    output logic              csr_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef META_ARB_PERF_EN
    ,
    output logic [31:0]       perf_dma_cnt,
    output logic [31:0]       perf_sch_cnt,
    output logic [31:0]       perf_csr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        req, gnt;
    logic              lock_hold;

    logic              mem_en_q, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Stage 0 coincides with the mem_en cycle; stage RD_LAT is the return cycle.
    logic [RD_LAT:0]   rd_vld_q, rd_vld_d;
    logic [RD_LAT:0]   rd_own_q, rd_own_d;
    logic              rd_issue;

    logic [DATA_W-1:0] sch_rdata_q, csr_rdata_q;

    assign req       = {csr_req, sch_req, dma_req};
    assign lock_hold = (state_q == ARB_LOCK) && dma_lock;

    always_comb begin
        gnt = 3'b000;
        if (rst_n && !abort) begin
            if (lock_hold) begin
                gnt[0] = dma_req;
            end else begin
                case (rr_ptr_q)
                    2'd0: begin
                        if (req[0])      gnt = 3'b001;
                        else if (req[1]) gnt = 3'b010;
                        else if (req[2]) gnt = 3'b100;
                    end
                    2'd1: begin
                        if (req[1])      gnt = 3'b010;
                        else if (req[2]) gnt = 3'b100;
                        else if (req[0]) gnt = 3'b001;
                    end
                    default: begin
                        if (req[2])      gnt = 3'b100;
                        else if (req[0]) gnt = 3'b001;
                        else if (req[1]) gnt = 3'b010;
                    end
                endcase
            end
        end
    end

    assign dma_gnt = gnt[0];
    assign sch_gnt = gnt[1];
    assign csr_gnt = gnt[2];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt[0])      rr_ptr_d = 2'd1;
        else if (gnt[1]) rr_ptr_d = 2'd2;
        else if (gnt[2]) rr_ptr_d = 2'd0;
    end

    always_comb begin
        state_d = state_q;
        if (abort)                                  state_d = ARB_RR;
        else if (gnt[0] && dma_lock)                state_d = ARB_LOCK;
        else if (state_q == ARB_LOCK && !dma_lock)  state_d = ARB_RR;
    end

    always_comb begin
        mem_we_d    = gnt[0] | (gnt[2] & csr_we);
        mem_addr_d  = csr_addr;
        mem_wdata_d = csr_wdata;
        if (gnt[0]) begin
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
        end else if (gnt[1]) begin
            mem_addr_d  = sch_addr;
            mem_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_RR;
            rr_ptr_q    <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            mem_en_q <= |gnt;
            if (|gnt) begin
                mem_we_q    <= mem_we_d;
                mem_addr_q  <= mem_addr_d;
                mem_wdata_q <= mem_wdata_d;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign rd_issue = gnt[1] | (gnt[2] & ~csr_we);

    always_comb begin
        rd_vld_d = {rd_vld_q[RD_LAT-1:0], rd_issue};
        rd_own_d = {rd_own_q[RD_LAT-1:0], gnt[2]};
        if (abort) rd_vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q    <= '0;
            rd_own_q    <= '0;
            sch_rdata_q <= '0;
            csr_rdata_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
            if (sch_rvalid) sch_rdata_q <= mem_rdata;
            if (csr_rvalid) csr_rdata_q <= mem_rdata;
        end
    end

    // Return data is passed through in the return cycle and held afterwards.
    assign sch_rvalid = rd_vld_q[RD_LAT] & ~rd_own_q[RD_LAT];
    assign csr_rvalid = rd_vld_q[RD_LAT] &  rd_own_q[RD_LAT];
    assign sch_rdata  = sch_rvalid ? mem_rdata : sch_rdata_q;
    assign csr_rdata  = csr_rvalid ? mem_rdata : csr_rdata_q;
    assign busy       = |rd_vld_q;

`ifdef META_ARB_PERF_EN
    logic [31:0] perf_dma_q, perf_sch_q, perf_csr_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dma_q   <= '0;
            perf_sch_q   <= '0;
            perf_csr_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (gnt[0])                perf_dma_q   <= perf_dma_q + 32'd1;
            if (gnt[1])                perf_sch_q   <= perf_sch_q + 32'd1;
            if (gnt[2])                perf_csr_q   <= perf_csr_q + 32'd1;
            if ((|req) && !(|gnt))     perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_dma_cnt   = perf_dma_q;
    assign perf_sch_cnt   = perf_sch_q;
    assign perf_csr_cnt   = perf_csr_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
